// File: rtl/photon_col_seq_if.sv
// ---------------------------------------------------------------------------
// photon_col_seq_if
//
// Purpose : bundles the column-in / result-out streams of photon_col_seq.
//
// Signals :
//   in_valid  producer offers a column (in_data + in_seed)
//   in_ready  block can take a column this cycle
//   in_data   32-bit column, nibble i at bits [4i+3:4i]
//   in_seed   32-bit accumulator start value
//   out_valid out_data holds a finished result
//   out_ready consumer takes the result this cycle
//   out_data  32-bit result, nibble j at bits [4j+3:4j]
//
// Handshake : a transfer happens on a rising clock edge where valid and
//             ready are both high. Once valid is raised the sender keeps its
//             payload stable until that edge; ready may change freely and
//             never depends combinationally on valid.
//
// Modports  : master = column producer / result consumer (testbench side)
//             slave  = photon_col_seq
// ---------------------------------------------------------------------------
interface photon_col_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_seed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output in_seed,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_seed,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/photon_col_seq.sv
// ---------------------------------------------------------------------------
// photon_col_seq
//
// Purpose : PHOTON-style column step. For a 32-bit column x (eight nibbles)
//           and a 32-bit seed it computes
//             out nibble j = seed_j ^ XOR_i ( M[j][i] * S(x_i) )
//           with the product taken in GF(2^4) mod x^4+x+1. The column is
//           walked UNROLL nibbles per cycle, so a result takes 8/UNROLL
//           RUN cycles; the result does not depend on UNROLL.
//
// Parameters:
//   UNROLL    nibbles folded in per RUN cycle: 1, 2, 4 or 8
//
// Ports   :
//   g_clk     clock, all state on the rising edge
//   g_resetn  synchronous active-low reset
//   bus       photon_col_seq_if.slave (column in, result out)
//   busy      high while the FSM is in RUN
//   o_state   current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
// ---------------------------------------------------------------------------
module photon_col_seq #(
    parameter int UNROLL = 1
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    photon_col_seq_if.slave bus,
    output logic            busy,
    output logic [1:0]      o_state
);

    // -----------------------------------------------------------------------
    // Configuration guard
    // -----------------------------------------------------------------------
    generate
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
            $error("photon_col_seq: UNROLL must be 1, 2, 4 or 8");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // S-box, entry k at bits [4k+3:4k]:
    // S = {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2}
    localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;

    // Mixing matrix. Row j occupies bits [32j+31:32j]; inside a row the
    // coefficient for column nibble i sits at [4i+3:4i]. So M[j][i] is at
    // bit offset {j, i, 2'b00}.
    localparam logic [255:0] MTAB = {
        32'h32A5_AD1F,  // row 7: F,1,D,A,5,A,2,3
        32'hE113_A22C,  // row 6: C,2,2,A,3,1,1,E
        32'h69C4_F5E9,  // row 5: 9,E,5,F,4,C,9,6
        32'hDE5E_D9CF,  // row 4: F,C,9,D,E,5,E,D
        32'hEFDC_1561,  // row 3: 1,6,5,1,C,D,F,E
        32'h9D49_DD44,  // row 2: 4,4,D,D,9,4,D,9
        32'h2577_D89C,  // row 1: C,9,8,D,7,7,5,2
        32'h6582_B242   // row 0: 2,4,2,B,2,8,5,6
    };

    // The nibble counter is 3 bits wide; with UNROLL=8 the step wraps to 0,
    // which is harmless because the first (and only) group is also the last.
    localparam logic [2:0] STEP     = 3'(UNROLL);
    localparam logic [2:0] LAST_IDX = 3'(8 - UNROLL);

    // -----------------------------------------------------------------------
    // GF(2^4) arithmetic
    // -----------------------------------------------------------------------
    // Shift-and-add multiply: walk the bits of b, doubling a each step and
    // folding the x^4 carry back in as x+1 (0x3).
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] prod;
        logic [3:0] sh;
        prod = 4'h0;
        sh   = a;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) begin
                prod = prod ^ sh;
            end
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
        end
        return prod;
    endfunction

    // Contribution of column nibble i to all eight output nibbles.
    function automatic logic [31:0] col_contrib(input logic [31:0] x_word,
                                                input logic [2:0]  i);
        logic [3:0]  xn;
        logic [3:0]  s;
        logic [31:0] r;
        xn = x_word[{i, 2'b00} +: 4];
        s  = SBOX[{xn, 2'b00} +: 4];
        r  = 32'h0;
        for (int j = 0; j < 8; j++) begin
            r[j*4 +: 4] = gf_mul(MTAB[{3'(j), i, 2'b00} +: 4], s);
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_x;
    logic [31:0] r_acc;
    logic [2:0]  r_idx;

    state_t      w_next;
    logic        w_accept;
    logic        w_last;
    logic [31:0] w_contrib;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_last   = (r_idx == LAST_IDX);

    // XOR of the contributions of nibbles r_idx .. r_idx+UNROLL-1. The group
    // never crosses nibble 7 because r_idx is always a multiple of UNROLL.
    always_comb begin
        w_contrib = 32'h0;
        for (int u = 0; u < UNROLL; u++) begin
            w_contrib = w_contrib ^ col_contrib(r_x, r_idx + 3'(u));
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        busy          = (r_state == S_RUN);
        // The accumulator is only exposed while a result is on offer so the
        // bus reads 0 at all other times, including mid-computation.
        bus.out_data  = (r_state == S_DONE) ? r_acc : 32'h0;
        o_state       = r_state;
    end

    // -----------------------------------------------------------------------
    // Datapath: column capture and accumulation
    // -----------------------------------------------------------------------
    // Inputs are captured only on the accept edge; anything on in_data or
    // in_seed afterwards is ignored. r_acc keeps the result through DONE and
    // is only overwritten by the next accept.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_x   <= 32'h0;
            r_acc <= 32'h0;
            r_idx <= 3'd0;
        end else if (w_accept) begin
            r_x   <= bus.in_data;
            r_acc <= bus.in_seed;
            r_idx <= 3'd0;
        end else if (r_state == S_RUN) begin
            r_acc <= r_acc ^ w_contrib;
            r_idx <= r_idx + STEP;
        end
    end

endmodule

// File: tb/tb_photon_col_seq.sv
// ---------------------------------------------------------------------------
// tb_photon_col_seq
//
// Directed bench for photon_col_seq. One UNROLL=1 instance takes the
// directed vectors (hand-computed results, stall, reset aborts); four more
// instances with UNROLL=1,2,4,8 take random back-to-back columns checked
// against a bench-side reference model.
// ---------------------------------------------------------------------------
module tb_photon_col_seq;

    localparam int BOUND  = 40;
    localparam int N_RAND = 1000;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    logic g_resetn;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // -----------------------------------------------------------------------
    // Reference tables (typed in by index order)
    // -----------------------------------------------------------------------
    localparam logic [3:0] TB_S [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] TB_M [8][8] = '{
        '{4'h2, 4'h4, 4'h2, 4'hB, 4'h2, 4'h8, 4'h5, 4'h6},
        '{4'hC, 4'h9, 4'h8, 4'hD, 4'h7, 4'h7, 4'h5, 4'h2},
        '{4'h4, 4'h4, 4'hD, 4'hD, 4'h9, 4'h4, 4'hD, 4'h9},
        '{4'h1, 4'h6, 4'h5, 4'h1, 4'hC, 4'hD, 4'hF, 4'hE},
        '{4'hF, 4'hC, 4'h9, 4'hD, 4'hE, 4'h5, 4'hE, 4'hD},
        '{4'h9, 4'hE, 4'h5, 4'hF, 4'h4, 4'hC, 4'h9, 4'h6},
        '{4'hC, 4'h2, 4'h2, 4'hA, 4'h3, 4'h1, 4'h1, 4'hE},
        '{4'hF, 4'h1, 4'hD, 4'hA, 4'h5, 4'hA, 4'h2, 4'h3}
    };

    // Carry-less product into 7 bits, then reduce by x^4+x+1 from the top.
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = 7'h0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ 7'({3'b000, a} << i);
        end
        for (int k = 6; k >= 4; k--) begin
            if (p[k]) p = p ^ 7'(7'b0010011 << (k - 4));
        end
        return p[3:0];
    endfunction

    function automatic logic [31:0] golden(input logic [31:0] x, input logic [31:0] seed);
        logic [31:0] r;
        logic [3:0]  s;
        r = seed;
        for (int i = 0; i < 8; i++) begin
            s = TB_S[x[i*4 +: 4]];
            for (int j = 0; j < 8; j++) begin
                r[j*4 +: 4] = r[j*4 +: 4] ^ gmul(TB_M[j][i], s);
            end
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Directed DUT (UNROLL=1)
    // -----------------------------------------------------------------------
    photon_col_seq_if pbus ();
    logic       p_busy;
    logic [1:0] p_state;

    photon_col_seq #(.UNROLL(1)) u_dut (
        .g_clk    (clk),
        .g_resetn (g_resetn),
        .bus      (pbus.slave),
        .busy     (p_busy),
        .o_state  (p_state)
    );

    // -----------------------------------------------------------------------
    // Random lanes, UNROLL = 1 << lane
    // -----------------------------------------------------------------------
    logic [3:0]  lane_ivalid;
    logic [31:0] lane_idata [4];
    logic [31:0] lane_iseed [4];
    logic [3:0]  lane_ready;
    logic [3:0]  lane_ovalid;
    logic [3:0]  lane_busy;
    logic [31:0] lane_odata [4];
    logic [7:0]  lane_state;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            photon_col_seq_if lbus ();
            assign lbus.in_valid   = lane_ivalid[gi];
            assign lbus.in_data    = lane_idata[gi];
            assign lbus.in_seed    = lane_iseed[gi];
            assign lbus.out_ready  = 1'b1;
            assign lane_ready[gi]  = lbus.in_ready;
            assign lane_ovalid[gi] = lbus.out_valid;
            assign lane_odata[gi]  = lbus.out_data;

            photon_col_seq #(.UNROLL(1 << gi)) u_lane (
                .g_clk    (clk),
                .g_resetn (g_resetn),
                .bus      (lbus.slave),
                .busy     (lane_busy[gi]),
                .o_state  (lane_state[2*gi +: 2])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    // Offers one column to the directed DUT, scrambles the inputs right after
    // the accept edge, and stops at the first cycle with out_valid high.
    task automatic run_col(input logic [31:0] x, input logic [31:0] seed,
                           input logic [31:0] exp);
        int n;
        int busy_n;
        pbus.in_data  = x;
        pbus.in_seed  = seed;
        pbus.in_valid = 1'b1;
        n = 0;
        while (!pbus.in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("col_ready", 32'(pbus.in_ready), 32'd1);
        @(negedge clk);
        pbus.in_valid = 1'b0;
        pbus.in_data  = ~x;
        pbus.in_seed  = x ^ 32'hA5A5_5A5A;
        n      = 0;
        busy_n = 0;
        while (!pbus.out_valid && n < BOUND) begin
            if (p_busy) busy_n++;
            @(negedge clk);
            n++;
        end
        chk("col_latency", n, 32'd8);
        chk("col_busy_cycles", busy_n, 32'd8);
        chk("col_data", pbus.out_data, exp);
    endtask

    // Outputs expected in IDLE: ready, nothing on offer, data bus zero.
    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(pbus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(pbus.out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(p_busy), 32'd0);
        chk({tag, "_out_data"}, pbus.out_data, 32'd0);
    endtask

    // Streams N_RAND random columns through lane k with in_valid held high
    // and out_ready tied high; checks data, latency and accept spacing.
    task automatic run_lane(input int k, input int u);
        logic [31:0] x;
        logic [31:0] s;
        int cyc;
        int prev;
        int lat;
        int n;
        int nrun;
        nrun = 8 / u;
        cyc  = 0;
        prev = -1;
        for (int c = 0; c < N_RAND; c++) begin
            x = $urandom;
            s = $urandom;
            lane_idata[k]  = x;
            lane_iseed[k]  = s;
            lane_ivalid[k] = 1'b1;
            exp_q.push_back(golden(x, s));
            n = 0;
            while (!lane_ready[k] && n < BOUND) begin
                @(negedge clk);
                cyc++;
                n++;
            end
            chk("lane_ready", 32'(lane_ready[k]), 32'd1);
            if (prev >= 0) chk("lane_spacing", cyc - prev, nrun + 2);
            prev = cyc;
            @(negedge clk);
            cyc++;
            chk("lane_busy", 32'(lane_busy[k]), 32'd1);
            lat = 0;
            while (!lane_ovalid[k] && lat < BOUND) begin
                @(negedge clk);
                cyc++;
                lat++;
            end
            chk("lane_latency", lat, nrun);
            chk("lane_data", lane_odata[k], exp_q.pop_front());
        end
        lane_ivalid[k] = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    // Directed vectors: x, seed, expected (hand-computed)
    // -----------------------------------------------------------------------
    localparam int NDV = 7;
    localparam logic [31:0] DV_X [NDV] = '{
        32'h5555_5555, 32'h5555_5550, 32'h5555_5550, 32'h5555_5505,
        32'h5555_5500, 32'h5555_5555, 32'h5555_5551
    };
    localparam logic [31:0] DV_S [NDV] = '{
        32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
        32'h0000_0000, 32'h1234_5678, 32'h0000_0000
    };
    localparam logic [31:0] DV_E [NDV] = '{
        32'h0000_0000, 32'h8F68_C5FB, 32'h7097_3A04, 32'hCB4F_E565,
        32'h4427_209E, 32'h1234_5678, 32'h69B6_579A
    };

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        int seen;
        g_resetn       = 1'b0;
        pbus.in_valid  = 1'b0;
        pbus.in_data   = 32'h0;
        pbus.in_seed   = 32'h0;
        pbus.out_ready = 1'b1;
        lane_ivalid    = 4'h0;
        for (int k = 0; k < 4; k++) begin
            lane_idata[k] = 32'h0;
            lane_iseed[k] = 32'h0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst_state", 32'(p_state), 32'd0);
        g_resetn = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");

        // Directed columns, consumer always ready
        for (int v = 0; v < NDV; v++) begin
            run_col(DV_X[v], DV_S[v], DV_E[v]);
            @(negedge clk);
            chk_idle("after_col");
        end

        // Stall in DONE for 5 cycles with in_valid pulses
        pbus.out_ready = 1'b0;
        run_col(32'h5555_5550, 32'h0, 32'h8F68_C5FB);
        for (int c = 0; c < 5; c++) begin
            pbus.in_valid = ~c[0];
            pbus.in_data  = 32'h0123_4567;
            pbus.in_seed  = 32'h89AB_CDEF;
            @(negedge clk);
            chk("stall_out_valid", 32'(pbus.out_valid), 32'd1);
            chk("stall_out_data", pbus.out_data, 32'h8F68_C5FB);
            chk("stall_in_ready", 32'(pbus.in_ready), 32'd0);
        end
        pbus.in_valid  = 1'b0;
        pbus.out_ready = 1'b1;
        @(negedge clk);
        chk_idle("stall_release");
        run_col(32'h5555_5505, 32'h0, 32'hCB4F_E565);
        @(negedge clk);

        // Reset at RUN cycle 3 aborts the column
        pbus.in_data  = 32'h5555_5551;
        pbus.in_seed  = 32'h0;
        pbus.in_valid = 1'b1;
        @(negedge clk);
        pbus.in_valid = 1'b0;
        chk("abort_busy", 32'(p_busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        g_resetn = 1'b0;
        @(negedge clk);
        chk_idle("abort_run");
        g_resetn = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (pbus.out_valid) seen++;
        end
        chk("abort_no_result", seen, 32'd0);
        run_col(32'h5555_5550, 32'h0, 32'h8F68_C5FB);
        @(negedge clk);

        // Reset while a result waits in DONE
        pbus.out_ready = 1'b0;
        run_col(32'h5555_5551, 32'h0, 32'h69B6_579A);
        g_resetn = 1'b0;
        @(negedge clk);
        chk_idle("abort_done");
        g_resetn       = 1'b1;
        pbus.out_ready = 1'b1;
        @(negedge clk);
        run_col(32'h5555_5550, 32'hFFFF_FFFF, 32'h7097_3A04);
        @(negedge clk);

        // Random back-to-back columns for every UNROLL
        for (int k = 0; k < 4; k++) begin
            run_lane(k, 1 << k);
        end
        chk("lanes_idle", 32'(lane_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors, want completion", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/photon_col_seq.md
PHOTON_COL_SEQ -- requirements
Module: photon_col_seq

Interface
REQ-001 SHALL have parameter UNROLL, default 1, meaning nibbles processed per RUN cycle; legal values 1, 2, 4, 8; other values are a configuration error.
REQ-002 SHALL have port g_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port g_resetn, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the input column is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a column.
REQ-006 SHALL have port in_data, input, 32 bits: column x, nibble i at bits [4i+3:4i], i=0..7.
REQ-007 SHALL have port in_seed, input, 32 bits: accumulator start value (rs1-style chaining).
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port out_data, output, 32 bits: result, nibble j at bits [4j+3:4j].
REQ-011 SHALL have port busy, output, 1 bit: high when state is RUN.

Function
REQ-012 SHALL compute out_data nibble j = seed_j XOR (XOR over i=0..7 of M[j][i] * S(x_i)), with multiplication in GF(2^4) modulo x^4+x+1 (carry-out of the shift-left XORs 0x3).
REQ-013 SHALL use S = {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2}, indexed 0..F.
REQ-014 SHALL use these rows of M, j=0..7, each listing i=0..7: 2,4,2,B,2,8,5,6 / C,9,8,D,7,7,5,2 / 4,4,D,D,9,4,D,9 / 1,6,5,1,C,D,F,E / F,C,9,D,E,5,E,D / 9,E,5,F,4,C,9,6 / C,2,2,A,3,1,1,E / F,1,D,A,5,A,2,3.
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==RUN).
REQ-016 IDLE: on in_valid&&in_ready, SHALL register in_data into x_reg and in_seed into acc, clear nibble counter idx to 0, and go to RUN.
REQ-017 RUN: each cycle SHALL XOR into acc the column contributions of nibbles idx..idx+UNROLL-1 of x_reg, and advance idx by UNROLL.
REQ-018 RUN: when the final group (idx==8-UNROLL) is processed, SHALL go to DONE; RUN therefore lasts exactly 8/UNROLL cycles.
REQ-019 Latency SHALL be 8/UNROLL cycles from the accept edge to the first cycle with out_valid=1 (8 cycles for UNROLL=1).
REQ-020 DONE: out_data=acc SHALL be held stable while out_valid&&!out_ready; on out_valid&&out_ready, SHALL go to IDLE.
REQ-021 in_valid while not IDLE SHALL be ignored and no state changed; inputs SHALL be sampled only at the accept edge, so in_data/in_seed changes later have no effect.
REQ-022 Result SHALL be independent of UNROLL.
REQ-023 Back-to-back throughput SHALL be one column per 8/UNROLL+2 cycles (accept, RUN, DONE/handshake, IDLE).
REQ-024 out_data SHALL read 0 whenever out_valid=0.

Reset
REQ-025 When g_resetn=0 at a rising edge, SHALL set state=IDLE and clear acc, x_reg and idx to 0.
REQ-026 After reset, outputs SHALL be in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-027 Reset in RUN or DONE SHALL abort the column with no result emitted; the first post-reset accept SHALL behave normally.

Verification
REQ-028 SHALL check: seed=0, x=0x55555555 (all S=0) -> out_data=0x00000000 after 8/UNROLL cycles.
REQ-029 SHALL check: seed=0, x=0x55555550 -> out_data=0x8F68C5FB; repeat with seed=0xFFFFFFFF -> 0x70973A04.
REQ-030 SHALL check: out_ready held low 5 cycles in DONE -> out_valid=1 and out_data constant throughout, in_ready=0, and in_valid pulses ignored.
REQ-031 SHALL check: g_resetn pulsed low at RUN cycle 3 -> next cycle in_ready=1, out_valid=0, busy=0; the following column 0x55555550 gives 0x8F68C5FB.
REQ-032 SHALL check: 1000 random back-to-back columns with out_ready always 1, for UNROLL=1,2,4,8 -> each matches a golden model of REQ-012, and spacing is 8/UNROLL+2 cycles.
